// File: rtl/sdrstick_rx_pkg.sv
// Shared constants, state encoding and a channel-search helper for the
// multi-channel receiver sample multiplexer.
package sdrstick_rx_pkg;

  localparam logic [3:0]  ADDR_CTRL       = 4'd0;
  localparam logic [3:0]  ADDR_RATE       = 4'd1;
  localparam logic [3:0]  ADDR_OVERFLOW   = 4'd2;
  localparam logic [3:0]  ADDR_FRAMES     = 4'd3;
  localparam logic [3:0]  ADDR_PHASE_BASE = 4'd8;

  localparam logic [7:0]  HDR_MAGIC   = 8'hA5;
  localparam logic [31:0] RESET_PHASE = 32'd2863313051;
  localparam logic [5:0]  RESET_RATE  = 6'd10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_I,
    ST_Q
  } rx_state_e;

  // Lowest set bit of mask at index >= first; result is {found, index}.
  function automatic logic [3:0] find_channel(input logic [7:0] mask, input logic [3:0] first);
    logic [3:0] r;
    r = 4'h0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i] && (4'(i) >= first)) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/sdrstick_rx_chan_capture.sv
// One receiver channel's capture register with its valid flag and an
// overflow pulse raised when unread data is overwritten.
module sdrstick_rx_chan_capture #(
  parameter int SAMPLE_WIDTH = 24
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           arm,
  input  logic                           strobe,
  input  logic                           take,
  input  logic signed [SAMPLE_WIDTH-1:0] in_i,
  input  logic signed [SAMPLE_WIDTH-1:0] in_q,
  output logic signed [SAMPLE_WIDTH-1:0] cap_i,
  output logic signed [SAMPLE_WIDTH-1:0] cap_q,
  output logic                           valid,
  output logic                           overflow
);

  logic capture;

  assign capture = enable && arm && strobe;
  // Overwriting on the edge the frame takes the old sample loses nothing.
  assign overflow = capture && valid && !take;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
    end else if (!enable) begin
      valid <= 1'b0;
    end else if (capture) begin
      valid <= 1'b1;
    end else if (take) begin
      valid <= 1'b0;
    end
  end

  // NOTE: sample data carries no reset; valid alone says whether it means anything.
  always_ff @(posedge clk) begin
    if (capture) begin
      cap_i <= in_i;
      cap_q <= in_q;
    end
  end

endmodule

// File: rtl/sdrstick_rx_mux.sv
// Multi-channel I/Q capture, framing and FIFO emission with the CPU-visible
// control registers (enable, mask, tag, rate, overflow, frames, phase words).
module sdrstick_rx_mux
  import sdrstick_rx_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int SAMPLE_WIDTH = 24
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CHANNELS-1:0]          in_strobe,
  input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] in_i,
  input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] in_q,
  input  logic                             fifo_full,
  output logic [31:0]                      fifo_writedata,
  output logic                             fifo_write,
  input  logic [3:0]                       ctl_address,
  input  logic                             ctl_read,
  input  logic                             ctl_write,
  input  logic [31:0]                      ctl_writedata,
  output logic [31:0]                      ctl_readdata,
  output logic [NUM_CHANNELS*32-1:0]       phase_word,
  output logic [5:0]                       rate,
  output logic                             debug_led
);

  localparam logic [7:0] CHAN_BITS = 8'((1 << NUM_CHANNELS) - 1);

  logic        enable, tag, enable_eff, frame_start;
  logic [7:0]  mask, active_mask, valid, ovf, take;
  logic [7:0]  seq, frame_seq;
  logic [31:0] ovf_count, frames, rd_data;
  logic [32:0] ovf_sum;
  logic [3:0]  ovf_inc, first_ch, next_ch;
  logic [2:0]  ch;
  rx_state_e   state;

  logic signed [SAMPLE_WIDTH-1:0] cap_i [8];
  logic signed [SAMPLE_WIDTH-1:0] cap_q [8];
  logic signed [SAMPLE_WIDTH-1:0] bank_i [8];
  logic signed [SAMPLE_WIDTH-1:0] bank_q [8];

  // A CTRL write clearing enable must stop capture and emission on that same edge.
  assign enable_eff  = (ctl_write && ctl_address == ADDR_CTRL) ? ctl_writedata[0] : enable;
  assign frame_start = (state == ST_IDLE) && enable_eff && (mask != 8'h0) && ((valid & mask) == mask);
  assign take        = frame_start ? mask : 8'h0;

  for (genvar n = 0; n < 8; n++) begin : g_chan
    if (n < NUM_CHANNELS) begin : g_live
      sdrstick_rx_chan_capture #(.SAMPLE_WIDTH(SAMPLE_WIDTH)) u_cap (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable_eff),
        .arm      (mask[n]),
        .strobe   (in_strobe[n]),
        .take     (take[n]),
        .in_i     (in_i[n*SAMPLE_WIDTH +: SAMPLE_WIDTH]),
        .in_q     (in_q[n*SAMPLE_WIDTH +: SAMPLE_WIDTH]),
        .cap_i    (cap_i[n]),
        .cap_q    (cap_q[n]),
        .valid    (valid[n]),
        .overflow (ovf[n])
      );
    end else begin : g_none
      assign cap_i[n] = '0;
      assign cap_q[n] = '0;
      assign valid[n] = 1'b0;
      assign ovf[n]   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (frame_start) begin
      for (int n = 0; n < 8; n++) begin
        bank_i[n] <= cap_i[n];
        bank_q[n] <= cap_q[n];
      end
    end
  end

  // NOTE: combinational blocks assign a default first so no path can infer a latch.
  always_comb begin
    ovf_inc = 4'h0;
    for (int n = 0; n < 8; n++) ovf_inc = ovf_inc + {3'b0, ovf[n]};
    ovf_sum  = {1'b0, ovf_count} + 33'(ovf_inc);
    first_ch = find_channel(mask, 4'h0);
    next_ch  = find_channel(active_mask, {1'b0, ch} + 4'd1);
  end

  assign fifo_write = (state != ST_IDLE) && !fifo_full;
  assign debug_led  = (state != ST_IDLE);

  always_comb begin
    fifo_writedata = 32'h0;
    case (state)
      ST_HDR:  fifo_writedata = {HDR_MAGIC, frame_seq, active_mask, 8'(NUM_CHANNELS)};
      ST_I:    fifo_writedata = 32'(bank_i[ch]);
      ST_Q:    fifo_writedata = 32'(bank_q[ch]);
      default: fifo_writedata = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      ch          <= 3'd0;
      seq         <= 8'd0;
      frame_seq   <= 8'd0;
      active_mask <= 8'h0;
      frames      <= 32'd0;
    end else if (!enable_eff) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            active_mask <= mask;
            frame_seq   <= seq;
            seq         <= seq + 8'd1;
            frames      <= frames + 32'd1;
            ch          <= first_ch[2:0];
            state       <= tag ? ST_HDR : ST_I;
          end
        end
        ST_HDR: if (fifo_write) state <= ST_I;
        ST_I:   if (fifo_write) state <= ST_Q;
        ST_Q: begin
          if (fifo_write) begin
            if (next_ch[3]) begin
              ch    <= next_ch[2:0];
              state <= ST_I;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_data = 32'h0;
    case (ctl_address)
      ADDR_CTRL:     rd_data = {16'h0, mask, 6'h0, tag, enable};
      ADDR_RATE:     rd_data = {26'h0, rate};
      ADDR_OVERFLOW: rd_data = ovf_count;
      ADDR_FRAMES:   rd_data = frames;
      default: begin
        if (ctl_address[3] && (int'(ctl_address[2:0]) < NUM_CHANNELS))
          rd_data = phase_word[{ctl_address[2:0], 5'b0} +: 32];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable       <= 1'b0;
      tag          <= 1'b0;
      mask         <= 8'h0;
      rate         <= RESET_RATE;
      phase_word   <= {NUM_CHANNELS{RESET_PHASE}};
      ovf_count    <= 32'd0;
      ctl_readdata <= 32'd0;
    end else begin
      if (ctl_write) begin
        case (ctl_address)
          ADDR_CTRL: begin
            enable <= ctl_writedata[0];
            tag    <= ctl_writedata[1];
            mask   <= ctl_writedata[15:8] & CHAN_BITS;
          end
          ADDR_RATE: rate <= ctl_writedata[5:0];
          default: begin
            if ((ctl_address & ADDR_PHASE_BASE) != 4'h0 && (int'(ctl_address[2:0]) < NUM_CHANNELS))
              phase_word[{ctl_address[2:0], 5'b0} +: 32] <= ctl_writedata;
          end
        endcase
      end
      if (ctl_write && ctl_address == ADDR_OVERFLOW) ovf_count <= 32'd0;
      else if (ovf_sum[32])                          ovf_count <= 32'hFFFF_FFFF;
      else                                           ovf_count <= ovf_sum[31:0];
      if (ctl_read && !ctl_write) ctl_readdata <= rd_data;
    end
  end

endmodule

// File: tb/tb_sdrstick_rx_mux.sv
// Directed bench: an expected-word queue built from the sample values drives
// a per-cycle compare of everything written to the FIFO.
module tb_sdrstick_rx_mux;

  localparam int NC = 4;
  localparam int SW = 24;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NC-1:0]        in_strobe;
  logic [NC*SW-1:0]     in_i, in_q;
  logic                 fifo_full;
  logic [31:0]          fifo_writedata;
  logic                 fifo_write;
  logic [3:0]           ctl_address;
  logic                 ctl_read, ctl_write;
  logic [31:0]          ctl_writedata, ctl_readdata;
  logic [NC*32-1:0]     phase_word;
  logic [5:0]           rate;
  logic                 debug_led;

  sdrstick_rx_mux #(.NUM_CHANNELS(NC), .SAMPLE_WIDTH(SW)) dut (
    .clk(clk), .reset(reset), .in_strobe(in_strobe), .in_i(in_i), .in_q(in_q),
    .fifo_full(fifo_full), .fifo_writedata(fifo_writedata), .fifo_write(fifo_write),
    .ctl_address(ctl_address), .ctl_read(ctl_read), .ctl_write(ctl_write),
    .ctl_writedata(ctl_writedata), .ctl_readdata(ctl_readdata),
    .phase_word(phase_word), .rate(rate), .debug_led(debug_led)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int words_seen = 0;
  logic [31:0] exp_q[$];
  int samp_i [NC];
  int samp_q [NC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Every FIFO write must match the next expected word; a stalled word must hold.
  always @(negedge clk) begin
    if (!reset) begin
      if (fifo_full && debug_led) begin
        check("no_write_when_full", {31'b0, fifo_write}, 32'd0);
        if (exp_q.size() > 0) check("held_word", fifo_writedata, exp_q[0]);
      end
      if (fifo_write) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got %08h expected no write", fifo_writedata);
        end else begin
          check("fifo_word", fifo_writedata, exp_q.pop_front());
          words_seen++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl_wr(input logic [3:0] a, input logic [31:0] d);
    ctl_address = a; ctl_writedata = d; ctl_write = 1'b1;
    tick();
    ctl_write = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [3:0] a, input logic [31:0] e);
    ctl_address = a; ctl_read = 1'b1;
    tick();
    ctl_read = 1'b0;
    check(name, ctl_readdata, e);
  endtask

  task automatic strobe(input logic [NC-1:0] which);
    for (int n = 0; n < NC; n++) begin
      in_i[n*SW +: SW] = samp_i[n][SW-1:0];
      in_q[n*SW +: SW] = samp_q[n][SW-1:0];
    end
    in_strobe = which;
    tick();
    in_strobe = '0;
  endtask

  function automatic void set_samples(input int seed);
    for (int n = 0; n < NC; n++) begin
      samp_i[n] = (n % 2 == 0) ? seed * 8191 + n * 3 : -(seed * 4099 + n);
      samp_q[n] = (n == 3) ? -8388608 : 1000 * n - seed * 77;
    end
  endfunction

  function automatic logic [31:0] hdr_word(input logic [7:0] s, input logic [7:0] m);
    return {8'hA5, s, m, 8'(NC)};
  endfunction

  // Samples in an int already hold the true signed value, i.e. the 32-bit sign-extended word.
  function automatic void push_body(input logic [7:0] m);
    for (int n = 0; n < NC; n++) begin
      if (m[n]) begin
        exp_q.push_back(samp_i[n]);
        exp_q.push_back(samp_q[n]);
      end
    end
  endfunction

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), 0);
    tick();
  endtask

  task automatic wait_words(input string name, input int target);
    int n = 0;
    while (words_seen < target && n < 300) begin
      tick();
      n++;
    end
    check(name, words_seen, target);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  int base;

  initial begin
    in_strobe = '0; in_i = '0; in_q = '0; fifo_full = 1'b0;
    ctl_address = '0; ctl_read = 1'b0; ctl_write = 1'b0; ctl_writedata = '0;
    reset = 1'b1;
    repeat (3) tick();
    check("reset_fifo_write", {31'b0, fifo_write}, 32'd0);
    check("reset_debug_led", {31'b0, debug_led}, 32'd0);
    check("reset_readdata", ctl_readdata, 32'd0);
    check("reset_rate", {26'b0, rate}, 32'd10);
    for (int n = 0; n < NC; n++) check("reset_phase_out", phase_word[n*32 +: 32], 32'd2863313051);
    reset = 1'b0;

    rd_check("phase0_reset", 4'd8, 32'd2863313051);
    rd_check("rate_reset", 4'd1, 32'd10);
    repeat (5) tick();

    // Register behaviour
    ctl_wr(4'd0, 32'h0000FF00);
    rd_check("ctrl_mask_clip", 4'd0, 32'h00000F00);
    ctl_address = 4'd1; ctl_writedata = 32'd20; ctl_write = 1'b1; ctl_read = 1'b1;
    tick();
    ctl_write = 1'b0; ctl_read = 1'b0;
    check("rw_same_cycle_hold", ctl_readdata, 32'h00000F00);
    check("rate_out", {26'b0, rate}, 32'd20);
    ctl_wr(4'd9, 32'h12345678);
    check("phase1_out", phase_word[32 +: 32], 32'h12345678);
    rd_check("phase1_read", 4'd9, 32'h12345678);
    rd_check("unmapped_read", 4'd5, 32'd0);
    rd_check("phase_beyond_nc", 4'd13, 32'd0);
    ctl_wr(4'd3, 32'd7);
    rd_check("frames_readonly", 4'd3, 32'd0);

    // Two-channel frame, no tag, literal words
    ctl_wr(4'd0, 32'h00000301);
    samp_i[0] = -5; samp_q[0] = 7; samp_i[1] = 32'h7FFFFF; samp_q[1] = -32'h800000;
    exp_q.push_back(32'hFFFFFFFB); exp_q.push_back(32'h00000007);
    exp_q.push_back(32'h007FFFFF); exp_q.push_back(32'hFF800000);
    strobe(4'b0011);
    check("latency_edge_k", {31'b0, fifo_write}, 32'd0);
    tick();
    check("latency_edge_k1", {31'b0, fifo_write}, 32'd1);
    wait_drain("drain_two_ch");
    rd_check("frames_one", 4'd3, 32'd1);

    // Tagged four-channel frames from a fresh reset
    do_reset();
    ctl_wr(4'd0, 32'h00000F03);
    set_samples(1);
    exp_q.push_back(32'hA5000F04);
    push_body(8'h0F);
    base = words_seen;
    strobe(4'b1111);
    wait_drain("drain_tag0");
    check("tag_frame_len", words_seen - base, 32'd9);
    set_samples(2);
    exp_q.push_back(32'hA5010F04);
    push_body(8'h0F);
    strobe(4'b1111);
    wait_drain("drain_tag1");

    // Backpressure stall mid-frame
    set_samples(3);
    exp_q.push_back(hdr_word(8'd2, 8'h0F));
    push_body(8'h0F);
    base = words_seen;
    strobe(4'b1111);
    wait_words("stall_reach", base + 3);
    fifo_full = 1'b1;
    repeat (5) tick();
    check("stall_no_words", words_seen, base + 3);
    fifo_full = 1'b0;
    wait_drain("drain_stall");
    check("stall_frame_len", words_seen - base, 32'd9);

    // Overflow counting with an unstrobed masked channel
    ctl_wr(4'd0, 32'h00000301);
    set_samples(4);
    strobe(4'b0001);
    strobe(4'b0001);
    tick();
    rd_check("overflow_one", 4'd2, 32'd1);
    ctl_wr(4'd2, 32'hDEADBEEF);
    rd_check("overflow_cleared", 4'd2, 32'd0);
    ctl_wr(4'd0, 32'h00000000);

    // Disable during the Q word of channel 1, then re-enable
    ctl_wr(4'd0, 32'h00000F03);
    set_samples(5);
    exp_q.push_back(hdr_word(8'd3, 8'h0F));
    push_body(8'h0F);
    base = words_seen;
    strobe(4'b1111);
    wait_words("abort_reach", base + 4);
    check("abort_led_busy", {31'b0, debug_led}, 32'd1);
    ctl_wr(4'd0, 32'h00000F02);
    check("abort_write_low", {31'b0, fifo_write}, 32'd0);
    check("abort_led_low", {31'b0, debug_led}, 32'd0);
    repeat (3) tick();
    check("abort_still_low", {31'b0, fifo_write}, 32'd0);
    check("abort_words", words_seen, base + 5);
    check("abort_leftover", exp_q.size(), 32'd4);
    exp_q.delete();
    ctl_wr(4'd0, 32'h00000F03);
    set_samples(6);
    exp_q.push_back(32'hA5040F04);
    push_body(8'h0F);
    strobe(4'b1111);
    wait_drain("drain_reenable");
    rd_check("frames_total", 4'd3, 32'd5);
    rd_check("overflow_final", 4'd2, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
